// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit processor: opcodes, instruction field
// positions, sequencer states and the writeback classifier.
package isa_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_ADDC  = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_SUBB  = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_MOVIL = 4'hB;
    localparam logic [3:0] OP_MOVIH = 4'hC;
    localparam logic [3:0] OP_LOAD  = 4'hD;
    localparam logic [3:0] OP_STORE = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        MEM     = 3'd4,
        HALT_ST = 3'd5,
        HALTED  = 3'd6
    } seq_state_t;

    // Every opcode from ADD through LOAD writes rd; NOP, STORE and HALT do not.
    function automatic logic is_writeback(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LOAD);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits IR into register selects and
// immediate, and classifies the opcode for writeback, memory and flag steering.
module instr_decode
    import isa_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [3:0]  o_op,
    output logic [2:0]  o_rd,
    output logic [2:0]  o_rs,
    output logic [2:0]  o_rt,
    output logic [7:0]  o_imm,
    output logic        o_movil,
    output logic        o_movih,
    output logic        o_writeback,
    output logic        o_load,
    output logic        o_store,
    output logic        o_mem,
    output logic        o_halt,
    output logic        o_carry_alu,
    output logic        o_borrow_alu
);

    logic [3:0] w_op;

    assign w_op  = i_ir[OP_MSB:OP_LSB];
    assign o_op  = w_op;
    assign o_rd  = i_ir[RD_MSB:RD_LSB];
    assign o_rs  = i_ir[RS_MSB:RS_LSB];
    assign o_rt  = i_ir[RT_MSB:RT_LSB];
    assign o_imm = i_ir[IMM_MSB:IMM_LSB];

    assign o_movil     = (w_op == OP_MOVIL);
    assign o_movih     = (w_op == OP_MOVIH);
    assign o_writeback = is_writeback(w_op);
    assign o_load      = (w_op == OP_LOAD);
    assign o_store     = (w_op == OP_STORE);
    assign o_mem       = (w_op == OP_LOAD) || (w_op == OP_STORE);
    assign o_halt      = (w_op == OP_HALT);

    // Only the arithmetic ops take their flags from the ALU; the rest hold them.
    assign o_carry_alu  = (w_op == OP_ADD) || (w_op == OP_ADDC);
    assign o_borrow_alu = (w_op == OP_SUB) || (w_op == OP_SUBB);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller; owns the PC and IR and drives
// the register-file write side, the ALU function and the data-memory handshake.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk_pi,
    input  logic                reset_n_pi,
    input  logic                start_pi,
    output logic                instr_req_po,
    output logic [PC_WIDTH-1:0] instr_addr_po,
    input  logic                instr_valid_pi,
    input  logic [15:0]         instr_pi,
    output logic [2:0]          source_reg1_po,
    output logic [2:0]          source_reg2_po,
    output logic [2:0]          destination_reg_po,
    input  logic [15:0]         reg1_data_pi,
    input  logic [15:0]         regD_data_pi,
    output logic [3:0]          alu_func_po,
    input  logic [15:0]         alu_result_pi,
    input  logic                alu_carry_pi,
    input  logic                alu_borrow_pi,
    input  logic                current_carry_pi,
    input  logic                current_borrow_pi,
    output logic                rf_clk_en_po,
    output logic                wr_destination_reg_po,
    output logic [15:0]         dest_result_data_po,
    output logic                movi_lower_po,
    output logic                movi_higher_po,
    output logic [7:0]          immediate_po,
    output logic                new_carry_po,
    output logic                new_borrow_po,
    output logic                mem_req_po,
    output logic                mem_we_po,
    output logic [15:0]         mem_addr_po,
    output logic [15:0]         mem_wdata_po,
    input  logic                mem_ack_pi,
    input  logic [15:0]         mem_rdata_pi,
    output logic                halted_po
);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_ir;

    logic [3:0] w_op;
    logic [2:0] w_rd;
    logic [2:0] w_rs;
    logic [2:0] w_rt;
    logic [7:0] w_imm;
    logic       w_movil;
    logic       w_movih;
    logic       w_writeback;
    logic       w_load;
    logic       w_store;
    logic       w_mem;
    logic       w_halt;
    logic       w_carry_alu;
    logic       w_borrow_alu;
    logic       w_accept;
    logic       w_retire;

    instr_decode u_decode (
        .i_ir         (r_ir),
        .o_op         (w_op),
        .o_rd         (w_rd),
        .o_rs         (w_rs),
        .o_rt         (w_rt),
        .o_imm        (w_imm),
        .o_movil      (w_movil),
        .o_movih      (w_movih),
        .o_writeback  (w_writeback),
        .o_load       (w_load),
        .o_store      (w_store),
        .o_mem        (w_mem),
        .o_halt       (w_halt),
        .o_carry_alu  (w_carry_alu),
        .o_borrow_alu (w_borrow_alu)
    );

    assign w_accept = (r_state == FETCH) && instr_valid_pi;
    assign w_retire = (r_state == EXEC) || (r_state == HALT_ST)
                   || ((r_state == MEM) && mem_ack_pi);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_pi) w_state_nxt = FETCH;
            FETCH:   if (instr_valid_pi) w_state_nxt = DECODE;
            DECODE: begin
                if (w_mem)       w_state_nxt = MEM;
                else if (w_halt) w_state_nxt = HALT_ST;
                else             w_state_nxt = EXEC;
            end
            EXEC:    w_state_nxt = FETCH;
            MEM:     if (mem_ack_pi) w_state_nxt = FETCH;
            HALT_ST: w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ir <= instr_pi;
                r_pc <= r_pc + PC_WIDTH'(1);
            end
        end
    end

    assign instr_req_po       = (r_state == FETCH);
    assign instr_addr_po      = r_pc;
    assign source_reg1_po     = w_rs;
    assign source_reg2_po     = w_rt;
    assign destination_reg_po = w_rd;
    assign alu_func_po        = w_op;
    assign immediate_po       = w_imm;

    // Every register-file side effect is qualified by the single retire pulse.
    assign rf_clk_en_po          = w_retire;
    assign wr_destination_reg_po = w_retire && w_writeback;
    assign movi_lower_po         = w_retire && w_movil;
    assign movi_higher_po        = w_retire && w_movih;
    assign dest_result_data_po   = w_load ? mem_rdata_pi : alu_result_pi;
    assign new_carry_po          = w_carry_alu  ? alu_carry_pi  : current_carry_pi;
    assign new_borrow_po         = w_borrow_alu ? alu_borrow_pi : current_borrow_pi;

    assign mem_req_po   = (r_state == MEM);
    assign mem_we_po    = (r_state == MEM) && w_store;
    assign mem_addr_po  = reg1_data_pi;
    assign mem_wdata_po = regD_data_pi;

    assign halted_po = (r_state == HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: an 8-bit-PC instance carries the main
// checks, a 2-bit-PC instance shares its stimulus to show PC wrap.
module tb_instr_sequencer;

    logic        clk_pi = 1'b0;
    logic        reset_n_pi;
    logic        start_pi;
    logic        instr_valid_pi;
    logic [15:0] instr_pi;
    logic [15:0] reg1_data_pi;
    logic [15:0] regD_data_pi;
    logic [15:0] alu_result_pi;
    logic        alu_carry_pi;
    logic        alu_borrow_pi;
    logic        current_carry_pi;
    logic        current_borrow_pi;
    logic        mem_ack_pi;
    logic [15:0] mem_rdata_pi;

    logic        instr_req_po;
    logic [7:0]  instr_addr_po;
    logic [2:0]  source_reg1_po, source_reg2_po, destination_reg_po;
    logic [3:0]  alu_func_po;
    logic        rf_clk_en_po, wr_destination_reg_po;
    logic [15:0] dest_result_data_po;
    logic        movi_lower_po, movi_higher_po;
    logic [7:0]  immediate_po;
    logic        new_carry_po, new_borrow_po;
    logic        mem_req_po, mem_we_po;
    logic [15:0] mem_addr_po, mem_wdata_po;
    logic        halted_po;

    logic        b_instr_req;
    logic [1:0]  b_instr_addr;
    logic [2:0]  b_src1, b_src2, b_dst;
    logic [3:0]  b_alu_func;
    logic        b_rf_clk_en, b_wr;
    logic [15:0] b_dest_data;
    logic        b_movi_l, b_movi_h;
    logic [7:0]  b_imm;
    logic        b_new_c, b_new_b;
    logic        b_mem_req, b_mem_we;
    logic [15:0] b_mem_addr, b_mem_wdata;
    logic        b_halted;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk_pi = ~clk_pi;

    instr_sequencer #(.PC_WIDTH(8), .RESET_PC(8'd0)) u_dut (
        .clk_pi(clk_pi), .reset_n_pi(reset_n_pi), .start_pi(start_pi),
        .instr_req_po(instr_req_po), .instr_addr_po(instr_addr_po),
        .instr_valid_pi(instr_valid_pi), .instr_pi(instr_pi),
        .source_reg1_po(source_reg1_po), .source_reg2_po(source_reg2_po),
        .destination_reg_po(destination_reg_po),
        .reg1_data_pi(reg1_data_pi), .regD_data_pi(regD_data_pi),
        .alu_func_po(alu_func_po), .alu_result_pi(alu_result_pi),
        .alu_carry_pi(alu_carry_pi), .alu_borrow_pi(alu_borrow_pi),
        .current_carry_pi(current_carry_pi), .current_borrow_pi(current_borrow_pi),
        .rf_clk_en_po(rf_clk_en_po), .wr_destination_reg_po(wr_destination_reg_po),
        .dest_result_data_po(dest_result_data_po),
        .movi_lower_po(movi_lower_po), .movi_higher_po(movi_higher_po),
        .immediate_po(immediate_po), .new_carry_po(new_carry_po),
        .new_borrow_po(new_borrow_po), .mem_req_po(mem_req_po), .mem_we_po(mem_we_po),
        .mem_addr_po(mem_addr_po), .mem_wdata_po(mem_wdata_po),
        .mem_ack_pi(mem_ack_pi), .mem_rdata_pi(mem_rdata_pi), .halted_po(halted_po)
    );

    instr_sequencer #(.PC_WIDTH(2), .RESET_PC(2'd0)) u_dut_w2 (
        .clk_pi(clk_pi), .reset_n_pi(reset_n_pi), .start_pi(start_pi),
        .instr_req_po(b_instr_req), .instr_addr_po(b_instr_addr),
        .instr_valid_pi(instr_valid_pi), .instr_pi(instr_pi),
        .source_reg1_po(b_src1), .source_reg2_po(b_src2), .destination_reg_po(b_dst),
        .reg1_data_pi(reg1_data_pi), .regD_data_pi(regD_data_pi),
        .alu_func_po(b_alu_func), .alu_result_pi(alu_result_pi),
        .alu_carry_pi(alu_carry_pi), .alu_borrow_pi(alu_borrow_pi),
        .current_carry_pi(current_carry_pi), .current_borrow_pi(current_borrow_pi),
        .rf_clk_en_po(b_rf_clk_en), .wr_destination_reg_po(b_wr),
        .dest_result_data_po(b_dest_data),
        .movi_lower_po(b_movi_l), .movi_higher_po(b_movi_h),
        .immediate_po(b_imm), .new_carry_po(b_new_c), .new_borrow_po(b_new_b),
        .mem_req_po(b_mem_req), .mem_we_po(b_mem_we),
        .mem_addr_po(b_mem_addr), .mem_wdata_po(b_mem_wdata),
        .mem_ack_pi(mem_ack_pi), .mem_rdata_pi(mem_rdata_pi), .halted_po(b_halted)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pi);
        #1;
    endtask

    // Presents one word in FETCH and returns in DECODE with the bus idle again.
    task automatic fetch(input logic [15:0] w, input string tag);
        check_val({tag, "_req"}, {31'd0, instr_req_po}, 32'd1);
        instr_valid_pi = 1'b1;
        instr_pi       = w;
        tick();
        instr_valid_pi = 1'b0;
        instr_pi       = 16'h0000;
        #1;
    endtask

    logic [1:0] exp_w2_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n_pi = 1'b0; start_pi = 1'b0; instr_valid_pi = 1'b0; instr_pi = '0;
        reg1_data_pi = '0; regD_data_pi = '0; alu_result_pi = '0;
        alu_carry_pi = 1'b0; alu_borrow_pi = 1'b0;
        current_carry_pi = 1'b0; current_borrow_pi = 1'b0;
        mem_ack_pi = 1'b0; mem_rdata_pi = '0;
        #3;
        check_val("rst_req",    {31'd0, instr_req_po}, 32'd0);
        check_val("rst_addr",   {24'd0, instr_addr_po}, 32'd0);
        check_val("rst_rfen",   {31'd0, rf_clk_en_po}, 32'd0);
        check_val("rst_wr",     {31'd0, wr_destination_reg_po}, 32'd0);
        check_val("rst_memreq", {31'd0, mem_req_po}, 32'd0);
        check_val("rst_memwe",  {31'd0, mem_we_po}, 32'd0);
        check_val("rst_halted", {31'd0, halted_po}, 32'd0);
        check_val("rst_dst",    {29'd0, destination_reg_po}, 32'd0);
        check_val("rst_imm",    {24'd0, immediate_po}, 32'd0);
        check_val("rst_movil",  {31'd0, movi_lower_po}, 32'd0);
        check_val("rst_func",   {28'd0, alu_func_po}, 32'd0);
        @(negedge clk_pi);
        reset_n_pi = 1'b1;

        tick();
        check_val("idle_no_req", {31'd0, instr_req_po}, 32'd0);
        start_pi = 1'b1;
        tick();
        start_pi = 1'b0;
        check_val("fetch_addr0", {24'd0, instr_addr_po}, 32'd0);

        // ADD $3,$1,$2; a valid word offered in DECODE/EXEC must be ignored
        alu_result_pi = 16'd3; alu_carry_pi = 1'b1; current_carry_pi = 1'b0;
        fetch(16'h1650, "add");
        instr_valid_pi = 1'b1; instr_pi = 16'hF000;
        #1;
        check_val("add_dec_addr", {24'd0, instr_addr_po}, 32'd1);
        check_val("add_dec_rfen", {31'd0, rf_clk_en_po}, 32'd0);
        check_val("add_src1",     {29'd0, source_reg1_po}, 32'd1);
        check_val("add_src2",     {29'd0, source_reg2_po}, 32'd2);
        check_val("add_func",     {28'd0, alu_func_po}, 32'd1);
        tick();
        check_val("add_rfen",  {31'd0, rf_clk_en_po}, 32'd1);
        check_val("add_wr",    {31'd0, wr_destination_reg_po}, 32'd1);
        check_val("add_dst",   {29'd0, destination_reg_po}, 32'd3);
        check_val("add_data",  {16'd0, dest_result_data_po}, 32'd3);
        check_val("add_carry", {31'd0, new_carry_po}, 32'd1);
        instr_valid_pi = 1'b0; instr_pi = '0;
        tick();
        check_val("add_done_rfen", {31'd0, rf_clk_en_po}, 32'd0);

        // SUB: borrow from ALU, carry held
        alu_carry_pi = 1'b1; alu_borrow_pi = 1'b1;
        current_carry_pi = 1'b0; current_borrow_pi = 1'b0;
        fetch(16'h3650, "sub");
        tick();
        check_val("sub_borrow", {31'd0, new_borrow_po}, 32'd1);
        check_val("sub_carry",  {31'd0, new_carry_po}, 32'd0);
        tick();

        // MOVIL / MOVIH: flags pass through from the register file
        alu_carry_pi = 1'b0; alu_borrow_pi = 1'b0;
        current_carry_pi = 1'b1; current_borrow_pi = 1'b1;
        fetch(16'hBAAB, "movil");
        check_val("movil_dec_gated", {31'd0, movi_lower_po}, 32'd0);
        tick();
        check_val("movil_lane",  {31'd0, movi_lower_po}, 32'd1);
        check_val("movil_hlane", {31'd0, movi_higher_po}, 32'd0);
        check_val("movil_imm",   {24'd0, immediate_po}, 32'hAB);
        check_val("movil_dst",   {29'd0, destination_reg_po}, 32'd5);
        check_val("movil_wr",    {31'd0, wr_destination_reg_po}, 32'd1);
        check_val("movil_carry", {31'd0, new_carry_po}, 32'd1);
        check_val("movil_borrow",{31'd0, new_borrow_po}, 32'd1);
        tick();
        fetch(16'hCA12, "movih");
        tick();
        check_val("movih_lane",  {31'd0, movi_higher_po}, 32'd1);
        check_val("movih_llane", {31'd0, movi_lower_po}, 32'd0);
        check_val("movih_imm",   {24'd0, immediate_po}, 32'h12);
        check_val("movih_carry", {31'd0, new_carry_po}, 32'd1);
        check_val("movih_borrow",{31'd0, new_borrow_po}, 32'd1);
        tick();

        // LOAD $2,[$4] with ack on the third MEM cycle; early ack in DECODE ignored
        reg1_data_pi = 16'd4; mem_rdata_pi = 16'hBEEF; alu_result_pi = 16'd3;
        fetch(16'hD500, "load");
        mem_ack_pi = 1'b1;
        #1;
        check_val("load_dec_rfen", {31'd0, rf_clk_en_po}, 32'd0);
        tick();
        mem_ack_pi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ack_pi = 1'b1;
            #1;
            check_val("load_memreq", {31'd0, mem_req_po}, 32'd1);
            check_val("load_we",     {31'd0, mem_we_po}, 32'd0);
            check_val("load_addr",   {16'd0, mem_addr_po}, 32'd4);
            check_val("load_rfen",   {31'd0, rf_clk_en_po}, (i == 2) ? 32'd1 : 32'd0);
            if (i == 2) begin
                check_val("load_wr",   {31'd0, wr_destination_reg_po}, 32'd1);
                check_val("load_dst",  {29'd0, destination_reg_po}, 32'd2);
                check_val("load_data", {16'd0, dest_result_data_po}, 32'hBEEF);
            end
            tick();
        end
        mem_ack_pi = 1'b0;
        #1;
        check_val("load_after_req", {31'd0, mem_req_po}, 32'd0);
        check_val("load_refetch",   {31'd0, instr_req_po}, 32'd1);

        // STORE with same-cycle ack; start_pi held high must not disturb anything
        regD_data_pi = 16'h1234; start_pi = 1'b1;
        fetch(16'hE500, "store");
        tick();
        mem_ack_pi = 1'b1;
        #1;
        check_val("store_we",    {31'd0, mem_we_po}, 32'd1);
        check_val("store_wdata", {16'd0, mem_wdata_po}, 32'h1234);
        check_val("store_rfen",  {31'd0, rf_clk_en_po}, 32'd1);
        check_val("store_wr",    {31'd0, wr_destination_reg_po}, 32'd0);
        tick();
        mem_ack_pi = 1'b0; start_pi = 1'b0;
        #1;
        check_val("store_refetch", {31'd0, instr_req_po}, 32'd1);
        check_val("store_addr",    {24'd0, instr_addr_po}, 32'd6);

        // Reset while a LOAD waits in MEM
        fetch(16'hD500, "rstmem");
        tick();
        check_val("rstmem_req_pre", {31'd0, mem_req_po}, 32'd1);
        reset_n_pi = 1'b0;
        mem_ack_pi = 1'b1;
        #1;
        check_val("rstmem_req",  {31'd0, mem_req_po}, 32'd0);
        check_val("rstmem_rfen", {31'd0, rf_clk_en_po}, 32'd0);
        check_val("rstmem_wr",   {31'd0, wr_destination_reg_po}, 32'd0);
        check_val("rstmem_addr", {24'd0, instr_addr_po}, 32'd0);
        check_val("rstmem_dst",  {29'd0, destination_reg_po}, 32'd0);
        @(negedge clk_pi);
        mem_ack_pi = 1'b0;
        reset_n_pi = 1'b1;

        // NOP stream: 8-bit PC counts on, 2-bit PC wraps to 0
        start_pi = 1'b1;
        tick();
        start_pi = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_val("nop_addr",    {24'd0, instr_addr_po}, k);
            check_val("nop_addr_w2", {30'd0, b_instr_addr}, {30'd0, exp_w2_addr[k]});
            fetch(16'h0000, "nop");
            tick();
            check_val("nop_rfen", {31'd0, rf_clk_en_po}, 32'd1);
            check_val("nop_wr",   {31'd0, wr_destination_reg_po}, 32'd0);
            tick();
        end

        // HALT: retire pulse with flags held, then absorbing
        alu_carry_pi = 1'b1; alu_borrow_pi = 1'b1;
        current_carry_pi = 1'b0; current_borrow_pi = 1'b0;
        fetch(16'hF000, "halt");
        tick();
        check_val("halt_rfen",   {31'd0, rf_clk_en_po}, 32'd1);
        check_val("halt_wr",     {31'd0, wr_destination_reg_po}, 32'd0);
        check_val("halt_pre",    {31'd0, halted_po}, 32'd0);
        check_val("halt_carry",  {31'd0, new_carry_po}, 32'd0);
        check_val("halt_borrow", {31'd0, new_borrow_po}, 32'd0);
        tick();
        instr_valid_pi = 1'b1; instr_pi = 16'h1650; start_pi = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check_val("halted",      {31'd0, halted_po}, 32'd1);
            check_val("halted_req",  {31'd0, instr_req_po}, 32'd0);
            check_val("halted_rfen", {31'd0, rf_clk_en_po}, 32'd0);
            tick();
        end
        check_val("halted_w2", {31'd0, b_halted}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
